crc_param_engine: RTL and testbench

CRC_PARAM_ENGINE -- requirements
Module: crc_param_engine

---
 rtl/crc_param_engine_if.sv | 41 ++++
 rtl/crc_param_engine.sv | 173 +++++++++++++++++
 tb/tb_crc_param_engine.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_param_engine_if.sv
// crc_param_engine_if -- groups the configuration, byte stream, control
// pulses and result signals of crc_param_engine.
//   poly/init_val/xor_out : CRC algorithm description (CRC_W bits each)
//   refin/refout          : input-byte / output-CRC reflection enables
//   start/finish          : one-cycle control pulses
//   din/din_valid/din_ready : byte stream into the input FIFO
//   crc_out/crc_valid     : registered result and its one-cycle strobe
//   busy/count/overflow   : status
// master drives the engine (testbench / host), slave is the engine itself.
interface crc_param_engine_if #(
  parameter int CRC_W      = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CRC_W-1:0] poly;
  logic [CRC_W-1:0] init_val;
  logic [CRC_W-1:0] xor_out;
  logic             refin;
  logic             refout;
  logic             start;
  logic [7:0]       din;
  logic             din_valid;
  logic             din_ready;
  logic             finish;
  logic [CRC_W-1:0] crc_out;
  logic             crc_valid;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output poly, init_val, xor_out, refin, refout, start, din, din_valid, finish,
    input  din_ready, crc_out, crc_valid, busy, count, overflow
  );

  modport slave (
    input  poly, init_val, xor_out, refin, refout, start, din, din_valid, finish,
    output din_ready, crc_out, crc_valid, busy, count, overflow
  );
endinterface

// File: rtl/crc_param_engine.sv
// crc_param_engine -- bit-serial CRC engine with runtime polynomial, seed,
// final XOR and reflection options, fed through a first-word-fall-through
// byte FIFO. Each byte costs one pop cycle plus eight shift cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : crc_param_engine_if.slave (config, byte stream, start/finish,
//          crc_out/crc_valid result, busy/count/overflow status)
module crc_param_engine #(
  parameter int CRC_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input logic                clk,
  input logic                rst,
  crc_param_engine_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             ready;
  logic             fifo_empty;
  logic             push, pop;
  logic             do_shift, do_done;
  logic [7:0]       head;

  logic [CRC_W-1:0] crc;
  logic [7:0]       sh_byte;
  logic [2:0]       bitcnt;
  logic             fin_pend;
  logic [CRC_W-1:0] crc_out_r;
  logic             crc_valid_r;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] bitrev_crc(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  // One MSB-first LFSR step: feedback is the register MSB xored with the data bit.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic             b,
                                                input logic [CRC_W-1:0] p);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? p : '0);
  endfunction

  assign fifo_empty = (cnt == '0);
  assign ready      = (cnt < DEPTH_C);
  assign push       = bus.din_valid & ready;
  assign head       = mem[rd_ptr];

  assign bus.din_ready = ready;
  assign bus.busy      = !fifo_empty || (state != IDLE) || fin_pend;
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
  assign bus.crc_out   = crc_out_r;
  assign bus.crc_valid = crc_valid_r;

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst || bus.start) state <= IDLE;
    else                  state <= state_nxt;
  end

  // ---- FSM: next state and datapath strobes ----
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    do_shift  = 1'b0;
    do_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SHIFT;
        end else if (fin_pend) begin
          state_nxt = DONE;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        // Skipping IDLE when nothing is left to pop saves a cycle before DONE.
        if (bitcnt == 3'd7) state_nxt = (fifo_empty && fin_pend) ? DONE : IDLE;
      end
      DONE: begin
        do_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FIFO storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (push) mem[bus.start ? '0 : wr_ptr] <= bus.din;
  end

  // ---- FIFO pointers, occupancy, overflow flag ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (bus.start) begin
      // A byte accepted alongside start becomes the only entry.
      rd_ptr <= '0;
      wr_ptr <= push ? PTR_W'(1) : '0;
      cnt    <= push ? CNT_W'(1) : '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (bus.din_valid && !ready) ovf <= 1'b1;
    end
  end

  // ---- CRC datapath, finish bookkeeping, result register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      crc         <= '0;
      crc_out_r   <= '0;
      crc_valid_r <= 1'b0;
      fin_pend    <= 1'b0;
      bitcnt      <= '0;
    end else begin
      crc_valid_r <= 1'b0;
      if (bus.start) begin
        crc      <= bus.init_val;
        fin_pend <= 1'b0;
        bitcnt   <= '0;
      end else begin
        if (bus.finish) fin_pend <= 1'b1;
        if (pop) begin
          sh_byte <= bus.refin ? bitrev8(head) : head;
          bitcnt  <= '0;
        end
        if (do_shift) begin
          crc     <= crc_step(crc, sh_byte[7], bus.poly);
          sh_byte <= {sh_byte[6:0], 1'b0};
          bitcnt  <= bitcnt + 3'd1;
        end
        if (do_done) begin
          crc_out_r   <= (bus.refout ? bitrev_crc(crc) : crc) ^ bus.xor_out;
          crc_valid_r <= 1'b1;
          fin_pend    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_param_engine.sv
// Testbench for crc_param_engine: a 32-bit instance carries most scenarios,
// 16-bit and 8-bit instances join only for the "123456789" check strings.
// Expected results are queued when a job is issued; per-instance monitors
// pop and compare whenever crc_valid is seen.
module tb_crc_param_engine;

  logic clk = 1'b0;
  logic rst;
  logic aux_en;
  always #5 clk = ~clk;

  crc_param_engine_if #(.CRC_W(32), .FIFO_DEPTH(8)) if32 ();
  crc_param_engine_if #(.CRC_W(16), .FIFO_DEPTH(8)) if16 ();
  crc_param_engine_if #(.CRC_W(8),  .FIFO_DEPTH(8)) if8  ();

  crc_param_engine #(.CRC_W(32), .FIFO_DEPTH(8)) u32 (.clk(clk), .rst(rst), .bus(if32));
  crc_param_engine #(.CRC_W(16), .FIFO_DEPTH(8)) u16 (.clk(clk), .rst(rst), .bus(if16));
  crc_param_engine #(.CRC_W(8),  .FIFO_DEPTH(8)) u8i (.clk(clk), .rst(rst), .bus(if8));

  // Narrow instances share the byte stream but only see it while aux_en is set.
  assign if16.din       = if32.din;
  assign if16.din_valid = if32.din_valid & aux_en;
  assign if16.start     = if32.start & aux_en;
  assign if16.finish    = if32.finish & aux_en;
  assign if8.din        = if32.din;
  assign if8.din_valid  = if32.din_valid & aux_en;
  assign if8.start      = if32.start & aux_en;
  assign if8.finish     = if32.finish & aux_en;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] q32[$];
  logic [31:0] q16[$];
  logic [31:0] q8[$];
  logic [7:0]  msg [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference CRC-32 (reflected form, poly EDB88320, init/xor all ones).
  function automatic logic [31:0] crc32_ref(input logic [7:0] d[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (d[j]) begin
      c = c ^ {24'h0, d[j]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // ---- result monitors ----
  always @(negedge clk) begin
    if (if32.crc_valid === 1'b1) begin
      if (q32.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL crc32_unexpected: got pulse with crc_out=%h, expected no pulse", if32.crc_out);
      end else chk("crc32_result", if32.crc_out, q32.pop_front());
    end
  end

  always @(negedge clk) begin
    if (if16.crc_valid === 1'b1) begin
      if (q16.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL crc16_unexpected: got pulse with crc_out=%h, expected no pulse", if16.crc_out);
      end else chk("crc16_result", 32'(if16.crc_out), q16.pop_front());
    end
  end

  always @(negedge clk) begin
    if (if8.crc_valid === 1'b1) begin
      if (q8.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL crc8_unexpected: got pulse with crc_out=%h, expected no pulse", if8.crc_out);
      end else chk("crc8_result", 32'(if8.crc_out), q8.pop_front());
    end
  end

  // ---- stimulus helpers (entered and left on a falling edge) ----
  task automatic cfg32(input logic [31:0] p, input logic [31:0] iv, input logic [31:0] xo,
                       input logic ri, input logic ro);
    if32.poly = p; if32.init_val = iv; if32.xor_out = xo; if32.refin = ri; if32.refout = ro;
  endtask

  task automatic do_start();
    if32.start = 1'b1;
    @(negedge clk);
    if32.start = 1'b0;
  endtask

  task automatic pulse_finish();
    if32.finish = 1'b1;
    @(negedge clk);
    if32.finish = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic fin);
    int t = 0;
    while (!if32.din_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_ready_timeout", 32'(if32.din_ready), 32'd1);
    if32.din = b; if32.din_valid = 1'b1; if32.finish = fin;
    @(negedge clk);
    if32.din_valid = 1'b0; if32.finish = 1'b0;
  endtask

  task automatic wait_results();
    int t = 0;
    while ((q32.size() + q16.size() + q8.size()) != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("result_timeout", 32'(q32.size() + q16.size() + q8.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] acc[$];
    int first;
    rst = 1'b1; aux_en = 1'b1;
    if32.din = '0; if32.din_valid = 1'b0; if32.start = 1'b0; if32.finish = 1'b0;
    cfg32('0, '0, '0, 1'b0, 1'b0);
    if16.poly = '0; if16.init_val = '0; if16.xor_out = '0; if16.refin = 1'b0; if16.refout = 1'b0;
    if8.poly  = '0; if8.init_val  = '0; if8.xor_out  = '0; if8.refin  = 1'b0; if8.refout  = 1'b0;
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_count",     32'(if32.count), 32'd0);
    chk("rst_din_ready", 32'(if32.din_ready), 32'd1);
    chk("rst_busy",      32'(if32.busy), 32'd0);
    chk("rst_crc_out",   if32.crc_out, 32'd0);
    chk("rst_crc_valid", 32'(if32.crc_valid), 32'd0);
    chk("rst_overflow",  32'(if32.overflow), 32'd0);
    chk("rst_crc16_out", 32'(if16.crc_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // "123456789" on CRC-32, CRC-16/CCITT-FALSE and CRC-8
    cfg32(32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    if16.poly = 16'h1021; if16.init_val = 16'hFFFF;
    if8.poly  = 8'h07;
    do_start();
    for (int i = 0; i < 9; i++) send(msg[i], 1'b0);
    q32.push_back(32'hCBF4_3926);
    q16.push_back(32'h0000_29B1);
    q8.push_back(32'h0000_00F4);
    pulse_finish();
    wait_results();
    aux_en = 1'b0;

    // CRC-32/MPEG-2, finish in the same cycle as the last byte
    cfg32(32'h04C1_1DB7, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    do_start();
    for (int i = 0; i < 8; i++) send(msg[i], 1'b0);
    q32.push_back(32'h0376_E6E7);
    send(msg[8], 1'b1);
    wait_results();

    // Empty message, doubled finish -> single pulse of bitrev(init)^xor
    cfg32(32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    do_start();
    q32.push_back(32'h0000_0000);
    pulse_finish();
    pulse_finish();
    wait_results();

    // Latency: byte and finish together, crc_valid 11 cycles later
    do_start();
    acc = {8'h31};
    q32.push_back(crc32_ref(acc));
    if32.din = 8'h31; if32.din_valid = 1'b1; if32.finish = 1'b1;
    @(negedge clk);
    if32.din_valid = 1'b0; if32.finish = 1'b0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (if32.crc_valid === 1'b1 && first == 0) first = k;
    end
    chk("latency_edges", 32'(first), 32'd10);
    @(negedge clk);
    wait_results();

    // Overflow: 12 consecutive offers; bytes 0..8 and 11 are accepted
    do_start();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("ovf_ready_%0d", i), 32'(if32.din_ready), (i <= 8 || i == 11) ? 32'd1 : 32'd0);
      if32.din = 8'hA0 + 8'(i); if32.din_valid = 1'b1;
      @(negedge clk);
    end
    if32.din_valid = 1'b0;
    chk("ovf_count",    32'(if32.count), 32'd8);
    chk("ovf_flag",     32'(if32.overflow), 32'd1);
    acc = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hAB};
    q32.push_back(crc32_ref(acc));
    pulse_finish();
    wait_results();
    chk("ovf_sticky",   32'(if32.overflow), 32'd1);
    do_start();
    chk("ovf_cleared",  32'(if32.overflow), 32'd0);

    // start mid-SHIFT of the third byte with a byte in the same cycle
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    repeat (20) @(negedge clk);
    chk("restart_busy", 32'(if32.busy), 32'd1);
    if32.start = 1'b1; if32.din = 8'h5A; if32.din_valid = 1'b1;
    @(negedge clk);
    if32.start = 1'b0; if32.din_valid = 1'b0;
    chk("restart_count", 32'(if32.count), 32'd1);
    acc = {8'h5A};
    q32.push_back(crc32_ref(acc));
    pulse_finish();
    wait_results();

    // rst mid-SHIFT with finish pending: nothing must come out
    do_start();
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    pulse_finish();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_count",     32'(if32.count), 32'd0);
    chk("midrst_busy",      32'(if32.busy), 32'd0);
    chk("midrst_crc_out",   if32.crc_out, 32'd0);
    chk("midrst_din_ready", 32'(if32.din_ready), 32'd1);
    repeat (40) @(negedge clk);

    chk("leftover_expected", 32'(q32.size() + q16.size() + q8.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
